// File: rtl/fnd_scan_ms.sv
// rtl/fnd_scan_ms.sv - binary mm:ss to multiplexed 4-digit common-anode 7-segment display
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active low
//   min_q     binary minute count (0..59, >=60 shows dashes)
//   sec_q     binary second count (0..59, >=60 shows dashes)
//   sec_half  half-second flag, 0 lights the colon
//   blank     1 forces all digits off
//   com       digit enables, active low, com[3] = minute tens .. com[0] = second ones
//   seg       segments {g,f,e,d,c,b,a}, active low
//   dp        colon / decimal point, active low
module fnd_scan_ms #(
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] min_q,
   input  logic [5:0] sec_q,
   input  logic       sec_half,
   input  logic       blank,
   output logic [3:0] com,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [3:0] DASH = 4'd10;
   localparam logic [3:0] SEL0 = 4'b1000;

   typedef enum logic [1:0] {IDLE, CONV_M, CONV_S, DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [PW-1:0] r_pre;
   logic [1:0]    r_dig;

   // converter work registers
   logic [5:0] r_wm, r_ws;
   logic [2:0] r_tm, r_ts;
   logic       r_m_bad, r_s_bad, r_half_cap;

   // result registers (filled at DONE) and display registers (frame start)
   logic [3:0] r_res_mt, r_res_mo, r_res_st, r_res_so;
   logic       r_res_half;
   logic [3:0] r_dsp_mt, r_dsp_mo, r_dsp_st, r_dsp_so;
   logic       r_dsp_half;

   logic       w_frame_start, w_pre_wrap, w_on;
   logic [3:0] w_nx_mt, w_nx_mo, w_nx_st, w_nx_so, w_digit;
   logic       w_nx_half;

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    f_seg = 7'b1000000;
         4'd1:    f_seg = 7'b1111001;
         4'd2:    f_seg = 7'b0100100;
         4'd3:    f_seg = 7'b0110000;
         4'd4:    f_seg = 7'b0011001;
         4'd5:    f_seg = 7'b0010010;
         4'd6:    f_seg = 7'b0000010;
         4'd7:    f_seg = 7'b1111000;
         4'd8:    f_seg = 7'b0000000;
         4'd9:    f_seg = 7'b0010000;
         default: f_seg = 7'b0111111;
      endcase
   endfunction

   assign w_frame_start = (r_pre == '0) && (r_dig == 2'd0);
   assign w_pre_wrap    = (r_pre == PW'(SCAN_DIV - 1));
   assign w_on          = (r_pre >= PW'(GUARD)) && !blank;

   // Output registers are loaded on the same edge that commits a new frame,
   // so look through to the values the display registers are about to take.
   assign w_nx_mt   = w_frame_start ? r_res_mt   : r_dsp_mt;
   assign w_nx_mo   = w_frame_start ? r_res_mo   : r_dsp_mo;
   assign w_nx_st   = w_frame_start ? r_res_st   : r_dsp_st;
   assign w_nx_so   = w_frame_start ? r_res_so   : r_dsp_so;
   assign w_nx_half = w_frame_start ? r_res_half : r_dsp_half;

   always_comb begin
      w_digit = w_nx_mt;
      case (r_dig)
         2'd0: w_digit = w_nx_mt;
         2'd1: w_digit = w_nx_mo;
         2'd2: w_digit = w_nx_st;
         2'd3: w_digit = w_nx_so;
         default: w_digit = w_nx_mt;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_frame_start) w_state_nxt = CONV_M;
         CONV_M:  if (r_wm < 6'd10)  w_state_nxt = CONV_S;
         CONV_S:  if (r_ws < 6'd10)  w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_pre      <= '0;
         r_dig      <= 2'd0;
         r_wm       <= 6'd0;
         r_ws       <= 6'd0;
         r_tm       <= 3'd0;
         r_ts       <= 3'd0;
         r_m_bad    <= 1'b0;
         r_s_bad    <= 1'b0;
         r_half_cap <= 1'b0;
         r_res_mt   <= 4'd0;
         r_res_mo   <= 4'd0;
         r_res_st   <= 4'd0;
         r_res_so   <= 4'd0;
         r_res_half <= 1'b0;
         r_dsp_mt   <= 4'd0;
         r_dsp_mo   <= 4'd0;
         r_dsp_st   <= 4'd0;
         r_dsp_so   <= 4'd0;
         r_dsp_half <= 1'b0;
         com        <= 4'hF;
         seg        <= 7'h7F;
         dp         <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_pre   <= w_pre_wrap ? '0 : r_pre + 1'b1;
         if (w_pre_wrap) r_dig <= r_dig + 2'd1;

         if (w_frame_start) begin
            r_dsp_mt   <= r_res_mt;
            r_dsp_mo   <= r_res_mo;
            r_dsp_st   <= r_res_st;
            r_dsp_so   <= r_res_so;
            r_dsp_half <= r_res_half;
         end

         case (r_state)
            IDLE: if (w_frame_start) begin
               r_wm       <= min_q;
               r_ws       <= sec_q;
               r_tm       <= 3'd0;
               r_ts       <= 3'd0;
               r_m_bad    <= (min_q >= 6'd60);
               r_s_bad    <= (sec_q >= 6'd60);
               r_half_cap <= sec_half;
            end
            CONV_M: if (r_wm >= 6'd10) begin
               r_wm <= r_wm - 6'd10;
               r_tm <= r_tm + 3'd1;
            end
            CONV_S: if (r_ws >= 6'd10) begin
               r_ws <= r_ws - 6'd10;
               r_ts <= r_ts + 3'd1;
            end
            DONE: begin
               r_res_mt   <= r_m_bad ? DASH : {1'b0, r_tm};
               r_res_mo   <= r_m_bad ? DASH : r_wm[3:0];
               r_res_st   <= r_s_bad ? DASH : {1'b0, r_ts};
               r_res_so   <= r_s_bad ? DASH : r_ws[3:0];
               r_res_half <= r_half_cap;
            end
            default: ;
         endcase

         com <= w_on ? ~(SEL0 >> r_dig) : 4'hF;
         seg <= f_seg(w_digit);
         dp  <= !(w_on && (r_dig == 2'd1) && !w_nx_half);
      end
   end

endmodule
